// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at issue, parked in pending registers and committed after the modelled latency.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_CYCLES - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [7:0]  counter;
    logic [31:0] pendHi;
    logic [31:0] pendLo;

    logic [63:0] product;
    logic [31:0] magA;
    logic [31:0] magB;
    logic [31:0] magQ;
    logic [31:0] magR;
    logic        negQ;
    logic        negR;
    logic [31:0] resHi;
    logic [31:0] resLo;

    // Signed divide works on magnitudes so the INT_MIN / -1 case wraps cleanly to 0x80000000.
    always_comb begin
        product = 64'd0;
        magA    = srcA;
        magB    = srcB;
        negQ    = 1'b0;
        negR    = 1'b0;
        magQ    = 32'd0;
        magR    = 32'd0;
        resHi   = hi;
        resLo   = lo;

        if (mdOp == OP_DIV) begin
            magA = srcA[31] ? -srcA : srcA;
            magB = srcB[31] ? -srcB : srcB;
            negQ = srcA[31] ^ srcB[31];
            negR = srcA[31];
        end
        if (magB != 32'd0) begin
            magQ = magA / magB;
            magR = magA % magB;
        end

        case (mdOp)
            OP_MULT: begin
                product = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
                {resHi, resLo} = product;
            end
            OP_MULTU: begin
                product = {32'd0, srcA} * {32'd0, srcB};
                {resHi, resLo} = product;
            end
            OP_DIV, OP_DIVU: begin
                // Divide by zero leaves HI/LO exactly as they were before the operation.
                if (srcB != 32'd0) begin
                    resLo = negQ ? -magQ : magQ;
                    resHi = negR ? -magR : magR;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= 8'd0;
            busy    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pendHi  <= 32'd0;
            pendLo  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (mdOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                pendHi  <= resHi;
                                pendLo  <= resLo;
                                counter <= (mdOp == OP_MULT || mdOp == OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                                state   <= BUSY;
                                busy    <= 1'b1;
                            end
                            OP_MTHI: hi <= srcA;
                            OP_MTLO: lo <= srcA;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    if (counter != 8'd0) begin
                        counter <= counter - 8'd1;
                    end else begin
                        hi    <= pendHi;
                        lo    <= pendLo;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a table of directed operations plus hand-built
// sequences for reset, start-while-busy and abort-by-reset.
module tb_md_unit;

    localparam int MAX_WAIT = 300;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdOp  (mdOp),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCycles;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issue one operation at a negedge, then count negedges with busy high.
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cycles);
        @(negedge clk);
        start = 1'b1;
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        @(negedge clk);
        start  = 1'b0;
        mdOp   = 3'd0;
        srcA   = 32'hDEAD_BEEF;
        srcB   = 32'hCAFE_F00D;
        cycles = 0;
        while (busy && cycles < MAX_WAIT) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int cnt;
        logic sawBusy;

        vecs[0]  = '{"mthi",        3'd5, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0000_0000, 0};
        vecs[1]  = '{"mult -2*3",   3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[2]  = '{"multu",       3'd2, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
        vecs[3]  = '{"div -7/2",    3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[4]  = '{"divu 100/7",  3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10};
        vecs[5]  = '{"div ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[6]  = '{"mthi 5",      3'd5, 32'd5,         32'd0,         32'd5,         32'h8000_0000, 0};
        vecs[7]  = '{"mtlo 6",      3'd6, 32'd6,         32'd0,         32'd5,         32'd6,         0};
        vecs[8]  = '{"divu by 0",   3'd4, 32'd123,       32'd0,         32'd5,         32'd6,         10};
        vecs[9]  = '{"div by 0",    3'd3, 32'hFFFF_FF00, 32'd0,         32'd5,         32'd6,         10};
        vecs[10] = '{"op none",     3'd0, 32'd77,        32'd88,        32'd5,         32'd6,         0};
        vecs[11] = '{"op rsvd",     3'd7, 32'd77,        32'd88,        32'd5,         32'd6,         0};
        vecs[12] = '{"mult 7*-3",   3'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[13] = '{"div 7/-2",    3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[14] = '{"multu max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};

        reset = 1'b1;
        start = 1'b0;
        mdOp  = 3'd0;
        srcA  = 32'd0;
        srcB  = 32'd0;

        // Asynchronous reset between clock edges.
        #2 reset = 1'b0;
        #1;
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check({vecs[i].name, " cycles"}, cyc, vecs[i].expCycles);
            check({vecs[i].name, " hi"}, hi, vecs[i].expHi);
            check({vecs[i].name, " lo"}, lo, vecs[i].expLo);
        end

        // Mid-cycle reset clears HI/LO without any clock edge.
        runOp(3'd5, 32'hAAAA_5555, 32'd0, cyc);
        #2 reset = 1'b0;
        #1;
        check("midcycle reset hi", hi, 32'd0);
        check("midcycle reset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // start while busy: mtlo and a new div must both be ignored.
        @(negedge clk);
        start = 1'b1; mdOp = 3'd1; srcA = 32'd3; srcB = 32'd4;
        @(negedge clk);
        start = 1'b0; mdOp = 3'd0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) cnt++;
            if (k == 1) begin start = 1'b1; mdOp = 3'd6; srcA = 32'd99; end
            if (k == 2) begin
                check("busy lo held", lo, 32'd0);
                start = 1'b1; mdOp = 3'd3; srcA = 32'd100; srcB = 32'd7;
            end
            if (k == 3) begin start = 1'b0; mdOp = 3'd0; end
            @(negedge clk);
        end
        check("ignore busy cycles", cnt, 32'd5);
        check("ignore hi", hi, 32'd0);
        check("ignore lo", lo, 32'd12);
        check("ignore busy end", {31'd0, busy}, 32'd0);

        // Reset during a divide aborts it; no late commit.
        @(negedge clk);
        start = 1'b1; mdOp = 3'd4; srcA = 32'd100; srcB = 32'd7;
        @(negedge clk);
        start = 1'b0; mdOp = 3'd0;
        repeat (3) @(negedge clk);
        check("abort busy before", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        sawBusy = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) sawBusy = 1'b1;
            if (hi != 32'd0 || lo != 32'd0) cnt++;
        end
        check("abort no commit", cnt, 32'd0);
        check("abort no busy", {31'd0, sawBusy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, in the execute stage beside the ALU.
- Consumes the GRF read operands (regReadData1 as srcA, regReadData2 as srcB) and an operation code decoded by CTRL.
- Exposes HI/LO for mfhi/mflo write-back into the GRF write-data mux.
- Exposes busy so the fetch/control path stalls later md-class instructions until results commit.

Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (legal range 1..255).
- DIV_CYCLES, 10, cycles busy is held for div/divu (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  qualifies mdOp for one cycle.
- mdOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- srcA  input  32  rs operand.
- srcB  input  32  rt operand.
- busy  output  1  multiply/divide in progress.
- hi  output  32  HI register, registered.
- lo  output  32  LO register, registered.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, counter=0, hi=0, lo=0, busy=0, pending result registers=0. Takes effect immediately, independent of clk.
- Reset mid-operation aborts the operation; no partial HI/LO commit.
- FSM has two states: IDLE and BUSY.
- IDLE, start=1, mdOp in {1..4}, sampled at edge E0:
  - latch the computed result into pendHi/pendLo.
  - load counter = N-1 (N = MULT_CYCLES for 1,2; DIV_CYCLES for 3,4).
  - go to BUSY; busy=1 from E0.
- BUSY, each edge:
  - if counter != 0: counter decrements.
  - if counter == 0: hi<=pendHi, lo<=pendLo, go to IDLE, busy drops to 0 at the same edge.
  - Net effect: busy is high for exactly N cycles, and the new hi/lo are visible in the same cycle busy first reads 0 (after edge E0+N).
- IDLE, start=1, mdOp=5 (mthi): hi<=srcA at that edge; lo unchanged; busy stays 0.
- IDLE, start=1, mdOp=6 (mtlo): lo<=srcA at that edge; hi unchanged; busy stays 0.
- start while BUSY: ignored entirely (no restart, no mthi/mtlo write, operands not re-latched). Upstream must stall; the ignore is defensive.
- start=1 with mdOp 0 or 7: no effect.
- Arithmetic:
  - mult: 64-bit signed product of srcA×srcB; hi=product[63:32], lo=product[31:0].
  - multu: same split, unsigned product.
  - div (signed): lo=quotient truncated toward zero; hi=remainder, sign of dividend (srcA).
  - div overflow: srcA=32'h80000000, srcB=32'hFFFFFFFF gives lo=32'h80000000, hi=0.
  - divu: unsigned quotient and remainder.
  - Divide by zero (div or divu): full DIV_CYCLES latency, then hi/lo keep their pre-operation values. No trap, no X propagation.
- Operands are used only at E0; srcA/srcB changes while BUSY have no effect.
- hi/lo are read freely in any state; during BUSY they hold the old values.

Test Plan:
- Reset: drive reset=0 mid-cycle with no clock edge -> hi=0, lo=0, busy=0 immediately. Release; start mthi srcA=32'h12345678 -> hi=32'h12345678 after one edge, busy never 1.
- Signed mult: srcA=32'hFFFFFFFE (-2), srcB=3, mdOp=1 -> busy high exactly 5 cycles; then hi=32'hFFFFFFFF, lo=32'hFFFFFFFA. Same operands with multu -> hi=32'h00000002, lo=32'hFFFFFFFA.
- Signed div: srcA=-7 (32'hFFFFFFF9), srcB=2, mdOp=3 -> busy 10 cycles; then lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1). divu 100/7 -> lo=14, hi=2.
- Edge cases:
  - div 32'h80000000 by 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
  - After mthi 5 / mtlo 6, divu by 0 -> busy 10 cycles, then hi=5, lo=6.
- start during BUSY: begin mult 3×4, assert mtlo srcA=99 and a new div on cycles 2-3 -> both ignored; after 5 cycles hi=0, lo=12, busy=0.
- Reset mid-operation: start div 100/7, assert reset=0 on cycle 4 -> busy=0, hi=lo=0 at once. After release, no commit ever appears (hold 20 cycles, hi=lo=0).
